// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding and the hardwired zero register.
package hazard_defs;
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;
  localparam logic [4:0] REG_ZERO    = 5'd0;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller bundle. Performance counter ports exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_unit_if #(
  parameter int CNT_W = 32
);
  logic       fwd_en;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_two_src;
  logic [4:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_r_en;
  logic [4:0] mem_dest;
  logic       mem_wb_en;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       if_freeze;
  logic       id_freeze;
  logic       if_flush;
  logic       id_flush;
  logic       pipe_freeze;
  logic       mem_timeout_err;
  logic       haz_deadlock_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0] perf_mem;
  logic [CNT_W-1:0] perf_flush;
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be positive");
  end
`endif

  modport master (
    output fwd_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    input  if_freeze, id_freeze, if_flush, id_flush, pipe_freeze,
           mem_timeout_err, haz_deadlock_err
`ifdef HAZARD_PERF_CNT_EN
    , input perf_stall, perf_mem, perf_flush
`endif
  );

  modport slave (
    input  fwd_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    output if_freeze, id_freeze, if_flush, id_flush, pipe_freeze,
           mem_timeout_err, haz_deadlock_err
`ifdef HAZARD_PERF_CNT_EN
    , output perf_stall, perf_mem, perf_flush
`endif
  );
endinterface

// File: rtl/hazard_ctrl_unit_raw_cmp.sv
// Compares one ID source operand against the EXE and MEM destinations; $zero never creates a dependency.
module raw_cmp
  import hazard_defs::*;
(
  input  logic [4:0] src,
  input  logic [4:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic [4:0] mem_dest,
  input  logic       mem_wb_en,
  output logic       exe_hit,
  output logic       mem_hit
);
  logic live;

  assign live    = (src != REG_ZERO);
  assign exe_hit = live && exe_wb_en && (src == exe_dest);
  assign mem_hit = live && mem_wb_en && (src == mem_dest);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// MIPS pipeline freeze/flush controller: RAW bubbles, branch squash, SRAM stalls, watchdogs.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import hazard_defs::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int MAX_HAZ     = 4,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_ctrl_unit_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int HAZ_W  = $clog2(MAX_HAZ + 1);

  function automatic logic [WAIT_W-1:0] sat_wait(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_W'(MEM_TIMEOUT)) ? v : v + 1'b1;
  endfunction

  function automatic logic [HAZ_W-1:0] sat_haz(input logic [HAZ_W-1:0] v);
    return (v >= HAZ_W'(MAX_HAZ)) ? v : v + 1'b1;
  endfunction

  logic              exe_hit1, mem_hit1, exe_hit2, mem_hit2;
  logic              haz, mem_stall, squash, bubble;
  logic [0:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [HAZ_W-1:0]  haz_cnt;
  logic              timeout_err, deadlock_err;

  raw_cmp u_raw1 (
    .src(bus.id_src1), .exe_dest(bus.exe_dest), .exe_wb_en(bus.exe_wb_en),
    .mem_dest(bus.mem_dest), .mem_wb_en(bus.mem_wb_en),
    .exe_hit(exe_hit1), .mem_hit(mem_hit1)
  );

  raw_cmp u_raw2 (
    .src(bus.id_src2), .exe_dest(bus.exe_dest), .exe_wb_en(bus.exe_wb_en),
    .mem_dest(bus.mem_dest), .mem_wb_en(bus.mem_wb_en),
    .exe_hit(exe_hit2), .mem_hit(mem_hit2)
  );

  // With forwarding only a load in EXE cannot be bypassed; without it any pending write stalls.
  always_comb begin
    if (bus.fwd_en)
      haz = bus.exe_mem_r_en && (exe_hit1 || (bus.id_two_src && exe_hit2));
    else
      haz = exe_hit1 || mem_hit1 || (bus.id_two_src && (exe_hit2 || mem_hit2));
  end

  assign mem_stall = bus.mem_req && !bus.mem_ready;
  assign squash    = bus.branch_taken && !mem_stall;
  assign bubble    = haz && !mem_stall && !bus.branch_taken;

  always_comb begin
    bus.if_freeze        = 1'b0;
    bus.id_freeze        = 1'b0;
    bus.if_flush         = 1'b0;
    bus.id_flush         = 1'b0;
    bus.pipe_freeze      = 1'b0;
    bus.mem_timeout_err  = timeout_err && !rst;
    bus.haz_deadlock_err = deadlock_err && !rst;
    if (!rst) begin
      if (mem_stall) begin
        bus.pipe_freeze = 1'b1;
        bus.if_freeze   = 1'b1;
        bus.id_freeze   = 1'b1;
      end else if (squash) begin
        bus.if_flush = 1'b1;
        bus.id_flush = 1'b1;
      end else if (bubble) begin
        bus.if_freeze = 1'b1;
        bus.id_flush  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      haz_cnt      <= '0;
      timeout_err  <= 1'b0;
      deadlock_err <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        default: begin
          wait_cnt <= sat_wait(wait_cnt);
          if (sat_wait(wait_cnt) == WAIT_W'(MEM_TIMEOUT))
            timeout_err <= 1'b1;
          if (bus.mem_ready || !bus.mem_req)
            state <= ST_RUN;
        end
      endcase
      haz_cnt <= bubble ? sat_haz(haz_cnt) : '0;
      if (bubble && (sat_haz(haz_cnt) == HAZ_W'(MAX_HAZ)))
        deadlock_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] stall_cycles, mem_wait_cycles, flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles    <= '0;
      mem_wait_cycles <= '0;
      flush_count     <= '0;
    end else begin
      if (bubble)    stall_cycles    <= sat_cnt(stall_cycles);
      if (mem_stall) mem_wait_cycles <= sat_cnt(mem_wait_cycles);
      if (squash)    flush_count     <= sat_cnt(flush_count);
    end
  end

  assign bus.perf_stall = rst ? '0 : stall_cycles;
  assign bus.perf_mem   = rst ? '0 : mem_wait_cycles;
  assign bus.perf_flush = rst ? '0 : flush_count;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit; also covers the perf counters when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_ctrl_unit_if #(.CNT_W(32)) bus ();

  hazard_ctrl_unit #(.MEM_TIMEOUT(16), .MAX_HAZ(4), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [1:0]  err;
    logic [31:0] ps;
    logic [31:0] pm;
    logic [31:0] pf;
  } exp_t;

  exp_t sb_q[$];

  int          m_state, m_wait, m_haz;
  logic        m_mte, m_hde;
  logic [31:0] m_ps, m_pm, m_pf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_haz();
    logic e1, m1, e2, m2;
    e1 = (bus.id_src1 != 0) && bus.exe_wb_en && (bus.id_src1 == bus.exe_dest);
    m1 = (bus.id_src1 != 0) && bus.mem_wb_en && (bus.id_src1 == bus.mem_dest);
    e2 = bus.id_two_src && (bus.id_src2 != 0) && bus.exe_wb_en && (bus.id_src2 == bus.exe_dest);
    m2 = bus.id_two_src && (bus.id_src2 != 0) && bus.mem_wb_en && (bus.id_src2 == bus.mem_dest);
    if (bus.fwd_en) return bus.exe_mem_r_en && (e1 || e2);
    return e1 || m1 || e2 || m2;
  endfunction

  task automatic idle_inputs();
    bus.fwd_en = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_two_src = 0;
    bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
    bus.mem_dest = 0; bus.mem_wb_en = 0; bus.branch_taken = 0;
    bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  // One clock: push expectation for current inputs, compare at negedge, advance model at posedge.
  task automatic step(input string tag);
    exp_t e, g;
    logic stall, hz;
    stall = bus.mem_req && !bus.mem_ready;
    hz    = model_haz();
    e = '0;
    if (!rst) begin
      if (stall)                 e.ctrl = 5'b11001;
      else if (bus.branch_taken) e.ctrl = 5'b00110;
      else if (hz)               e.ctrl = 5'b10010;
      e.err = {m_mte, m_hde};
      e.ps = m_ps; e.pm = m_pm; e.pf = m_pf;
    end
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    chk({tag, ".ctrl"}, {27'd0, bus.if_freeze, bus.id_freeze, bus.if_flush, bus.id_flush, bus.pipe_freeze},
        {27'd0, g.ctrl});
    chk({tag, ".err"}, {30'd0, bus.mem_timeout_err, bus.haz_deadlock_err}, {30'd0, g.err});
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".ps"}, bus.perf_stall, g.ps);
    chk({tag, ".pm"}, bus.perf_mem, g.pm);
    chk({tag, ".pf"}, bus.perf_flush, g.pf);
`endif
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_wait = 0; m_haz = 0; m_mte = 0; m_hde = 0;
      m_ps = 0; m_pm = 0; m_pf = 0;
    end else begin
      if (m_state == 0) begin
        if (stall) begin m_state = 1; m_wait = 0; end
      end else begin
        if (m_wait < 16) m_wait++;
        if (m_wait == 16) m_mte = 1;
        if (bus.mem_ready || !bus.mem_req) m_state = 0;
      end
      if (!stall && !bus.branch_taken && hz) begin
        if (m_haz < 4) m_haz++;
        if (m_haz == 4) m_hde = 1;
        m_ps++;
      end else begin
        m_haz = 0;
      end
      if (stall) m_pm++;
      if (!stall && bus.branch_taken) m_pf++;
    end
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_state = 0; m_wait = 0; m_haz = 0; m_mte = 0; m_hde = 0;
    m_ps = 0; m_pm = 0; m_pf = 0;
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    step("reset0");
    step("reset1");
    rst = 0;
    step("idle");

    // Test 1: no forwarding, EXE match and MEM match both stall
    bus.id_src1 = 5; bus.exe_dest = 5; bus.exe_wb_en = 1;
    step("t1_exe");
    idle_inputs(); bus.id_src1 = 7; bus.mem_dest = 7; bus.mem_wb_en = 1;
    step("t1_mem");
    idle_inputs(); step("t1_gap");

    // Test 2: forwarding, only a load-use stalls for one cycle
    bus.fwd_en = 1; bus.id_src1 = 5; bus.exe_dest = 5; bus.exe_wb_en = 1;
    step("t2_alu");
    bus.exe_mem_r_en = 1;
    step("t2_load");
    bus.exe_mem_r_en = 0; bus.exe_wb_en = 0; bus.exe_dest = 0;
    bus.mem_dest = 5; bus.mem_wb_en = 1;
    step("t2_after");
    idle_inputs();

    // Test 3: $zero and unused src2 never stall
    bus.id_src2 = 0; bus.id_two_src = 1; bus.exe_dest = 0; bus.exe_wb_en = 1;
    step("t3_zero");
    bus.id_src2 = 9; bus.exe_dest = 9; bus.id_two_src = 0;
    step("t3_one_src");
    bus.id_two_src = 1;
    step("t3_two_src");
    idle_inputs(); step("t3_gap");

    // Test 4: squash wins over a bubble
    bus.id_src1 = 5; bus.exe_dest = 5; bus.exe_wb_en = 1; bus.branch_taken = 1;
    step("t4_squash");
    idle_inputs(); step("t4_gap");

    // Hazard held for five cycles trips the deadlock flag after MAX_HAZ
    bus.id_src1 = 3; bus.exe_dest = 3; bus.exe_wb_en = 1;
    for (int i = 0; i < 5; i++) step($sformatf("haz%0d", i));
    idle_inputs(); step("haz_gap");

    // Test 5: twenty-cycle SRAM stall with a branch arriving in cycle 3
    bus.mem_req = 1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) bus.branch_taken = 1;
      step($sformatf("t5_c%0d", i));
    end
    bus.mem_ready = 1;
    step("t5_ready");
    idle_inputs(); step("t5_gap");
    bus.mem_req = 1; bus.mem_ready = 1;
    step("t5_fast");
    bus.mem_ready = 0;
    step("t5_s1");
    step("t5_s2");
    bus.mem_req = 0;
    step("t5_drop");

    // Test 6: reset in the middle of a stall clears everything
    bus.mem_req = 1;
    for (int i = 0; i < 3; i++) step($sformatf("t6_s%0d", i));
    rst = 1;
    step("t6_rst");
    rst = 0; bus.mem_req = 0;
    step("t6_after");
    bus.branch_taken = 1;
    step("t6_flush");
    idle_inputs(); step("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
